// File: rtl/output_layer_if.sv
// Bus between the drowsiness-detector hidden layer / config master and the
// output neuron stage: weight write port, evaluation request and results.
interface output_layer_if #(
    parameter int N_IN      = 5,
    parameter int W_WIDTH   = 10,
    parameter int ACC_WIDTH = 14
);
    logic                  we;
    logic [2:0]            waddr;
    logic [W_WIDTH-1:0]    wdata;
    logic                  start;
    logic [N_IN-1:0]       hid_in;
    logic                  busy;
    logic                  done;
    logic [ACC_WIDTH-1:0]  score;
    logic                  drowsy;
    logic                  alarm;

    modport master (
        output we, waddr, wdata, start, hid_in,
        input  busy, done, score, drowsy, alarm
    );

    modport slave (
        input  we, waddr, wdata, start, hid_in,
        output busy, done, score, drowsy, alarm
    );
endinterface

// File: rtl/output_layer.sv
// Output neuron of the drowsiness detector. Accumulates bias plus the weights
// of the active hidden neurons over five cycles, thresholds the sum into a
// per-frame drowsy flag and raises alarm after a run of drowsy frames.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting; accepts weight writes, or start (write wins)
// ACC   | adds weight[idx] when hid_reg[idx] is set, one input per cycle
// FIN   | publishes score/drowsy/alarm, pulses done, updates run count
module output_layer #(
    parameter int N_IN        = 5,
    parameter int W_WIDTH     = 10,
    parameter int ACC_WIDTH   = 14,
    parameter int ALARM_COUNT = 4
) (
    input  logic          clk,
    input  logic          rst,
    output_layer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACC, FIN} state_t;

    localparam logic [2:0] LAST_IDX  = 3'(N_IN - 1);
    localparam logic [2:0] BIAS_ADDR = 3'(N_IN);
    localparam logic [2:0] ALARM_C   = 3'(ALARM_COUNT);

    state_t                       state;
    state_t                       state_nxt;
    logic                         wr_en;
    logic                         start_ok;

    logic signed [W_WIDTH-1:0]    weight [N_IN];
    logic signed [W_WIDTH-1:0]    bias;
    logic [N_IN-1:0]              hid_reg;
    logic [2:0]                   idx;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  addend;
    logic signed [W_WIDTH-1:0]    w_sel;
    logic [2:0]                   cnt;
    logic [2:0]                   cnt_nxt;
    logic                         drowsy_nxt;

    logic                         done_r;
    logic signed [ACC_WIDTH-1:0]  score_r;
    logic                         drowsy_r;
    logic                         alarm_r;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a write in IDLE takes priority over start
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        start_ok  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.we) begin
                    wr_en = 1'b1;
                end else if (bus.start) begin
                    start_ok  = 1'b1;
                    state_nxt = ACC;
                end
            end
            ACC: begin
                if (idx == LAST_IDX) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Term selected for this ACC cycle and the frame decision / run count
    always_comb begin
        w_sel      = weight[idx];
        addend     = hid_reg[idx] ? {{(ACC_WIDTH-W_WIDTH){w_sel[W_WIDTH-1]}}, w_sel}
                                  : '0;
        drowsy_nxt = !acc[ACC_WIDTH-1] && (acc != '0);
        if (drowsy_nxt) begin
            cnt_nxt = (cnt >= ALARM_C) ? ALARM_C : cnt + 3'd1;
        end else begin
            cnt_nxt = 3'd0;
        end
    end

    // Weight file, accumulator datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_IN; i++) begin
                weight[i] <= '0;
            end
            bias     <= '0;
            hid_reg  <= '0;
            idx      <= 3'd0;
            acc      <= '0;
            cnt      <= 3'd0;
            done_r   <= 1'b0;
            score_r  <= '0;
            drowsy_r <= 1'b0;
            alarm_r  <= 1'b0;
        end else begin
            done_r <= (state == FIN);

            if (wr_en) begin
                if (bus.waddr < BIAS_ADDR) begin
                    weight[bus.waddr] <= bus.wdata;
                end else if (bus.waddr == BIAS_ADDR) begin
                    bias <= bus.wdata;
                end
            end

            if (start_ok) begin
                hid_reg <= bus.hid_in;
                acc     <= {{(ACC_WIDTH-W_WIDTH){bias[W_WIDTH-1]}}, bias};
                idx     <= 3'd0;
            end

            if (state == ACC) begin
                acc <= acc + addend;
                idx <= (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
            end

            if (state == FIN) begin
                score_r  <= acc;
                drowsy_r <= drowsy_nxt;
                cnt      <= cnt_nxt;
                alarm_r  <= (cnt_nxt >= ALARM_C);
            end
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.done   = done_r;
    assign bus.score  = score_r;
    assign bus.drowsy = drowsy_r;
    assign bus.alarm  = alarm_r;
endmodule
